// File: rtl/atomrvcore_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atomrvcore_pkg: shared types and defaults for the atomRVCORE pipe     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package atomrvcore_pkg;

    localparam int c_DATAWIDTH_DFLT        = 32;
    localparam int c_REG_ADRESS_WIDTH_DFLT = 5;

    typedef enum logic [1:0] {
        EX_RUN      = 2'd0,
        EX_LD_STALL = 2'd1,
        EX_FLUSH    = 2'd2
    } ex_ctrl_state_e;

    localparam logic [1:0] c_EX_STATE_RST = 2'(EX_RUN);
    localparam logic       c_CTRL_RST     = 1'b0;

endpackage : atomrvcore_pkg
`default_nettype wire

// File: rtl/atomrvcore_ld_hazard_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atomrvcore_ld_hazard_det: load-use compare of decode vs ALU register  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module atomrvcore_ld_hazard_det
    import atomrvcore_pkg::*;
#(
    parameter int REG_ADRESS_WIDTH = c_REG_ADRESS_WIDTH_DFLT
) (
    input  logic                        id_valid_i,
    input  logic [REG_ADRESS_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADRESS_WIDTH-1:0] id_rs2_i,
    input  logic                        id_rs1_use_i,
    input  logic                        id_rs2_use_i,
    input  logic                        ex_valid_i,
    input  logic                        ex_load_i,
    input  logic                        ex_rwr_en_i,
    input  logic [REG_ADRESS_WIDTH-1:0] ex_rd_i,
    output logic                        hz_o
);

    logic w_ex_writes_load;
    logic w_rs1_match;
    logic w_rs2_match;

    // x0 is hard-wired, so a load targeting it never produces a dependency
    assign w_ex_writes_load = ex_valid_i & ex_load_i & ex_rwr_en_i & (ex_rd_i != '0);
    assign w_rs1_match      = id_rs1_use_i & (id_rs1_i == ex_rd_i);
    assign w_rs2_match      = id_rs2_use_i & (id_rs2_i == ex_rd_i);
    assign hz_o             = w_ex_writes_load & id_valid_i & (w_rs1_match | w_rs2_match);

endmodule : atomrvcore_ld_hazard_det
`default_nettype wire

// File: rtl/atomrvcore_ex_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atomrvcore_ex_ctrl: execute-stage stall/flush/redirect sequencer      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module atomrvcore_ex_ctrl
    import atomrvcore_pkg::*;
#(
    parameter int DATAWIDTH        = c_DATAWIDTH_DFLT,
    parameter int REG_ADRESS_WIDTH = c_REG_ADRESS_WIDTH_DFLT,
    parameter int FLUSH_DEPTH      = 2,
    parameter int LOAD_STALL_CYC   = 1,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        id_valid_i,
    input  logic [REG_ADRESS_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADRESS_WIDTH-1:0] id_rs2_i,
    input  logic                        id_rs1_use_i,
    input  logic                        id_rs2_use_i,
    input  logic                        ex_valid_i,
    input  logic                        ex_load_i,
    input  logic [REG_ADRESS_WIDTH-1:0] ex_rd_i,
    input  logic                        ex_rwr_en_i,
    input  logic                        ex_br_taken_i,
    input  logic                        ex_jal_i,
    input  logic                        ex_jalr_i,
    input  logic [DATAWIDTH-1:0]        ex_target_i,
    input  logic                        mem_busy_i,
    input  logic                        cnt_clr_i,
    output logic                        if_stall_o,
    output logic                        id_stall_o,
    output logic                        ex_stall_o,
    output logic                        ex_bubble_o,
    output logic                        if_flush_o,
    output logic                        id_flush_o,
    output logic                        redirect_o,
    output logic [DATAWIDTH-1:0]        redirect_pc_o,
    output logic [1:0]                  state_o,
    output logic [CNT_WIDTH-1:0]        stall_cnt_o,
    output logic [CNT_WIDTH-1:0]        flush_cnt_o
);

    localparam logic [1:0] c_ST_RUN      = 2'(EX_RUN);
    localparam logic [1:0] c_ST_LD_STALL = 2'(EX_LD_STALL);
    localparam logic [1:0] c_ST_FLUSH    = 2'(EX_FLUSH);

    localparam int c_DCNT_MAX = (FLUSH_DEPTH > LOAD_STALL_CYC) ? FLUSH_DEPTH - 1 : LOAD_STALL_CYC - 1;
    localparam int c_DCNT_W   = (c_DCNT_MAX > 1) ? $clog2(c_DCNT_MAX + 1) : 1;
    localparam logic [c_DCNT_W-1:0] c_FLUSH_INIT = c_DCNT_W'(FLUSH_DEPTH - 1);
    localparam logic [c_DCNT_W-1:0] c_LD_INIT    = c_DCNT_W'(LOAD_STALL_CYC - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_DCNT_W-1:0]  r_dcnt;
    logic [c_DCNT_W-1:0]  w_dcnt_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_hz;
    logic w_redir;
    logic w_if_stall, w_id_stall, w_ex_stall, w_bubble;
    logic w_if_flush, w_id_flush, w_redirect;
    logic [DATAWIDTH-1:0] w_redirect_pc;

    atomrvcore_ld_hazard_det #(
        .REG_ADRESS_WIDTH (REG_ADRESS_WIDTH)
    ) u_ld_hazard_det (
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_rs1_use_i (id_rs1_use_i),
        .id_rs2_use_i (id_rs2_use_i),
        .ex_valid_i   (ex_valid_i),
        .ex_load_i    (ex_load_i),
        .ex_rwr_en_i  (ex_rwr_en_i),
        .ex_rd_i      (ex_rd_i),
        .hz_o         (w_hz)
    );

    assign w_redir = ex_valid_i & (ex_br_taken_i | ex_jal_i | ex_jalr_i);

    always_comb begin
        w_if_stall    = 1'b0;
        w_id_stall    = 1'b0;
        w_ex_stall    = 1'b0;
        w_bubble      = 1'b0;
        w_if_flush    = 1'b0;
        w_id_flush    = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_state_nxt   = r_state;
        w_dcnt_nxt    = r_dcnt;

        // Memory busy freezes everything; the held ALU register replays any redirect later
        if (mem_busy_i) begin
            w_if_stall = 1'b1;
            w_id_stall = 1'b1;
            w_ex_stall = 1'b1;
            if (r_state == 2'd3) begin
                w_state_nxt = c_ST_RUN;
                w_dcnt_nxt  = '0;
            end
        end else begin
            case (r_state)
                c_ST_RUN, c_ST_LD_STALL: begin
                    if (w_redir) begin
                        w_redirect    = 1'b1;
                        w_if_flush    = 1'b1;
                        w_id_flush    = 1'b1;
                        w_bubble      = 1'b1;
                        w_redirect_pc = {ex_target_i[DATAWIDTH-1:1], ex_target_i[0] & ~ex_jalr_i};
                        if (FLUSH_DEPTH > 1) begin
                            w_state_nxt = c_ST_FLUSH;
                            w_dcnt_nxt  = c_FLUSH_INIT;
                        end else begin
                            w_state_nxt = c_ST_RUN;
                            w_dcnt_nxt  = '0;
                        end
                    end else if (r_state == c_ST_LD_STALL) begin
                        w_if_stall = 1'b1;
                        w_id_stall = 1'b1;
                        w_bubble   = 1'b1;
                        if (r_dcnt <= 1) begin
                            w_state_nxt = c_ST_RUN;
                            w_dcnt_nxt  = '0;
                        end else begin
                            w_dcnt_nxt = r_dcnt - 1'b1;
                        end
                    end else if (w_hz) begin
                        w_if_stall = 1'b1;
                        w_id_stall = 1'b1;
                        w_bubble   = 1'b1;
                        if (LOAD_STALL_CYC > 1) begin
                            w_state_nxt = c_ST_LD_STALL;
                            w_dcnt_nxt  = c_LD_INIT;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    w_if_flush = 1'b1;
                    w_id_flush = 1'b1;
                    w_bubble   = 1'b1;
                    if (r_dcnt <= 1) begin
                        w_state_nxt = c_ST_RUN;
                        w_dcnt_nxt  = '0;
                    end else begin
                        w_dcnt_nxt = r_dcnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_RUN;
                    w_dcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_EX_STATE_RST;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_id_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Outputs are forced low for the whole time reset is asserted
    assign if_stall_o    = rst_ni ? w_if_stall : c_CTRL_RST;
    assign id_stall_o    = rst_ni ? w_id_stall : c_CTRL_RST;
    assign ex_stall_o    = rst_ni ? w_ex_stall : c_CTRL_RST;
    assign ex_bubble_o   = rst_ni ? w_bubble   : c_CTRL_RST;
    assign if_flush_o    = rst_ni ? w_if_flush : c_CTRL_RST;
    assign id_flush_o    = rst_ni ? w_id_flush : c_CTRL_RST;
    assign redirect_o    = rst_ni ? w_redirect : c_CTRL_RST;
    assign redirect_pc_o = rst_ni ? w_redirect_pc : '0;
    assign state_o       = r_state;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;

endmodule : atomrvcore_ex_ctrl
`default_nettype wire

// File: tb/tb_atomrvcore_ex_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_atomrvcore_ex_ctrl: vector table + scoreboard bench for ex_ctrl    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_atomrvcore_ex_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        id_valid_i, id_rs1_use_i, id_rs2_use_i;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
    logic        ex_valid_i, ex_load_i, ex_rwr_en_i;
    logic        ex_br_taken_i, ex_jal_i, ex_jalr_i;
    logic [31:0] ex_target_i;
    logic        mem_busy_i, cnt_clr_i;
    logic        if_stall_o, id_stall_o, ex_stall_o, ex_bubble_o;
    logic        if_flush_o, id_flush_o, redirect_o;
    logic [31:0] redirect_pc_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    atomrvcore_ex_ctrl #(
        .DATAWIDTH        (32),
        .REG_ADRESS_WIDTH (5),
        .FLUSH_DEPTH      (2),
        .LOAD_STALL_CYC   (1),
        .CNT_WIDTH        (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_use_i  (id_rs1_use_i),
        .id_rs2_use_i  (id_rs2_use_i),
        .ex_valid_i    (ex_valid_i),
        .ex_load_i     (ex_load_i),
        .ex_rd_i       (ex_rd_i),
        .ex_rwr_en_i   (ex_rwr_en_i),
        .ex_br_taken_i (ex_br_taken_i),
        .ex_jal_i      (ex_jal_i),
        .ex_jalr_i     (ex_jalr_i),
        .ex_target_i   (ex_target_i),
        .mem_busy_i    (mem_busy_i),
        .cnt_clr_i     (cnt_clr_i),
        .if_stall_o    (if_stall_o),
        .id_stall_o    (id_stall_o),
        .ex_stall_o    (ex_stall_o),
        .ex_bubble_o   (ex_bubble_o),
        .if_flush_o    (if_flush_o),
        .id_flush_o    (id_flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .state_o       (state_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    // ctl bit order: {if_stall, id_stall, ex_stall, bubble, if_flush, id_flush, redirect}
    typedef struct {
        logic        idv, u1, u2, exv, ld, wr, br, jal, jalr, busy;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] tgt;
        logic [6:0]  ctl;
        logic [31:0] pc;
        logic [1:0]  st;
    } vec_t;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] pc;
        logic [1:0]  st;
        int          idx;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    function automatic vec_t mk(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic exv, input logic ld,
                                input logic [4:0] rd, input logic wr, input logic br,
                                input logic jal, input logic jalr, input logic [31:0] tgt,
                                input logic busy, input logic [6:0] ctl, input logic [31:0] pc,
                                input logic [1:0] st);
        vec_t v;
        v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exv = exv; v.ld = ld; v.rd = rd; v.wr = wr;
        v.br = br; v.jal = jal; v.jalr = jalr; v.tgt = tgt; v.busy = busy;
        v.ctl = ctl; v.pc = pc; v.st = st;
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {if_stall_o, id_stall_o, ex_stall_o, ex_bubble_o, if_flush_o, id_flush_o, redirect_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rs1_use_i = 0; id_rs2_use_i = 0;
        ex_valid_i = 0; ex_load_i = 0; ex_rd_i = 0; ex_rwr_en_i = 0;
        ex_br_taken_i = 0; ex_jal_i = 0; ex_jalr_i = 0; ex_target_i = 0;
        mem_busy_i = 0; cnt_clr_i = 0;
    endtask

    task automatic drive(input vec_t v, input int idx);
        exp_t e;
        id_valid_i = v.idv; id_rs1_i = v.rs1; id_rs2_i = v.rs2;
        id_rs1_use_i = v.u1; id_rs2_use_i = v.u2;
        ex_valid_i = v.exv; ex_load_i = v.ld; ex_rd_i = v.rd; ex_rwr_en_i = v.wr;
        ex_br_taken_i = v.br; ex_jal_i = v.jal; ex_jalr_i = v.jalr; ex_target_i = v.tgt;
        mem_busy_i = v.busy; cnt_clr_i = 0;
        e.ctl = v.ctl; e.pc = v.pc; e.st = v.st; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("vec%0d_ctl", e.idx), 32'(ctl_now()), 32'(e.ctl));
            chk($sformatf("vec%0d_state", e.idx), 32'(state_o), 32'(e.st));
            if (e.ctl[0])
                chk($sformatf("vec%0d_pc", e.idx), redirect_pc_o, e.pc);
        end
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 7'b0000000, 32'h0,    2'd0);
        vecs[1]  = mk(1, 5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 0, 32'h0,    0, 7'b1101000, 32'h0,    2'd0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 7'b0000000, 32'h0,    2'd0);
        vecs[3]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 32'h0,    0, 7'b0000000, 32'h0,    2'd0);
        vecs[4]  = mk(1, 3, 5, 1, 0, 1, 1, 5, 1, 0, 0, 0, 32'h0,    0, 7'b0000000, 32'h0,    2'd0);
        vecs[5]  = mk(1, 0, 5, 0, 1, 1, 1, 5, 0, 0, 0, 0, 32'h0,    0, 7'b0000000, 32'h0,    2'd0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 32'h1003, 0, 7'b0001111, 32'h1002, 2'd0);
        vecs[7]  = mk(1, 5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 0, 32'h0,    0, 7'b0001110, 32'h0,    2'd2);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 7'b0000000, 32'h0,    2'd0);
        vecs[9]  = mk(1, 5, 0, 1, 0, 1, 1, 5, 1, 1, 0, 0, 32'h2001, 0, 7'b0001111, 32'h2001, 2'd0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 7'b0001110, 32'h0,    2'd2);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h3000, 1, 7'b1110000, 32'h0,    2'd0);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h3000, 1, 7'b1110000, 32'h0,    2'd0);
        vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h3000, 1, 7'b1110000, 32'h0,    2'd0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h3000, 0, 7'b0001111, 32'h3000, 2'd0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 7'b0001110, 32'h0,    2'd2);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 7'b0000000, 32'h0,    2'd0);

        // Reset held with a live redirect and freeze on the inputs
        clear_inputs();
        rst_ni = 1'b0;
        ex_valid_i = 1; ex_jal_i = 1; ex_target_i = 32'h55; mem_busy_i = 1;
        @(negedge clk_i);
        chk("rst_ctl", 32'(ctl_now()), 32'd0);
        chk("rst_pc", redirect_pc_o, 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
        @(posedge clk_i); #1;
        clear_inputs();
        rst_ni = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk_i); #1;
            drive(vecs[i], i);
            @(negedge clk_i);
            check_head();
            if (i == 2)
                chk("stall_cnt_after_hz", 32'(stall_cnt_o), 32'd1);
            if (i == 8)
                chk("flush_cnt_after_jalr", 32'(flush_cnt_o), 32'd1);
        end
        chk("stall_cnt_table", 32'(stall_cnt_o), 32'd4);
        chk("flush_cnt_table", 32'(flush_cnt_o), 32'd3);

        // Saturate the stall counter through a long freeze
        clear_inputs();
        mem_busy_i = 1;
        repeat (65540) @(posedge clk_i);
        @(negedge clk_i);
        chk("stall_cnt_sat", 32'(stall_cnt_o), 32'hFFFF);
        @(negedge clk_i);
        chk("stall_cnt_sat_hold", 32'(stall_cnt_o), 32'hFFFF);
        cnt_clr_i = 1;
        @(negedge clk_i);
        chk("stall_cnt_clr", 32'(stall_cnt_o), 32'd0);
        chk("flush_cnt_clr", 32'(flush_cnt_o), 32'd0);
        cnt_clr_i = 0;
        @(negedge clk_i);
        chk("stall_cnt_after_clr", 32'(stall_cnt_o), 32'd1);

        // Asynchronous reset while flushing
        clear_inputs();
        ex_valid_i = 1; ex_jal_i = 1; ex_target_i = 32'h4000;
        @(posedge clk_i); #1;
        clear_inputs();
        @(negedge clk_i);
        chk("pre_rst_state", 32'(state_o), 32'd2);
        chk("pre_rst_ctl", 32'(ctl_now()), 32'b0001110);
        #1 rst_ni = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_ctl", 32'(ctl_now()), 32'd0);
        chk("mid_rst_pc", redirect_pc_o, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_state", 32'(state_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_atomrvcore_ex_ctrl
`default_nettype wire
